hdmi_axi_rd_burst: RTL and testbench

AXI4 read-burst master for the HDMI scan-out path. Sits directly downstream of the line address generator: it accepts one `kick`/`read_addr`/`read_num` request at a time and issues one INCR burst on the AR channel. It then streams the returned R-channel beats, one 32-bit pixel per beat, into the pixel line FIFO through a valid/ready push port. While a request is in flight it holds `busy` high, which paces the address generator.

---
 rtl/hdmi_axi_pkg.sv | 40 ++++
 rtl/hdmi_rd_err_mon.sv | 68 ++++++
 rtl/hdmi_axi_rd_burst.sv | 120 ++++++++++++
 tb/tb_hdmi_axi_rd_burst.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_axi_pkg.sv
// ============================================================================
// Module   : hdmi_axi_pkg
// Brief    : Shared AXI constants, read-burst FSM encoding and helpers for
//            the HDMI scan-out read master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hdmi_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_AR   = ST_AR,
    S_R    = ST_R,
    S_DONE = ST_DONE
  } rd_state_e;

  // AXI size code: log2 of the bus width in bytes.
  function automatic logic [2:0] clog2_bytes(input int unsigned data_w);
    int unsigned bytes;
    logic [2:0]  r;
    bytes = data_w / 8;
    r     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) < bytes) r = 3'(i + 1);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hdmi_rd_err_mon.sv
// ============================================================================
// Module   : hdmi_rd_err_mon
// Brief    : Beat counter and saturating error counter for read bursts:
//            counts error responses and bursts whose rlast is misplaced.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdmi_rd_err_mon
  import hdmi_axi_pkg::*;
(
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        start,
  input  logic        beat,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [7:0]  arlen,
  output logic [15:0] err_cnt
);

  localparam logic [8:0] c_idx_sat = 9'h100;

  logic [8:0]  r_idx;
  logic        r_len_err_seen;
  logic [15:0] r_err_cnt;

  logic        w_len_mismatch;
  logic        w_len_err;
  logic        w_resp_err;
  logic [1:0]  w_inc;
  logic [16:0] w_sum;

  // rlast must land exactly on beat index arlen; flag each burst at most once.
  assign w_len_mismatch = m_rlast_mismatch(rlast, r_idx, arlen);
  assign w_len_err      = beat & w_len_mismatch & ~r_len_err_seen;
  assign w_resp_err     = beat & (rresp != RESP_OKAY);
  assign w_inc          = {1'b0, w_len_err} + {1'b0, w_resp_err};
  assign w_sum          = {1'b0, r_err_cnt} + {15'd0, w_inc};

  function automatic logic m_rlast_mismatch(input logic last, input logic [8:0] idx,
                                            input logic [7:0] len);
    if (last) return idx != {1'b0, len};
    return idx == {1'b0, len};
  endfunction

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_idx          <= '0;
      r_len_err_seen <= 1'b0;
      r_err_cnt      <= '0;
    end else begin
      if (start) begin
        r_idx          <= '0;
        r_len_err_seen <= 1'b0;
      end else if (beat) begin
        if (r_idx != c_idx_sat) r_idx <= r_idx + 9'd1;
        if (w_len_err) r_len_err_seen <= 1'b1;
      end
      r_err_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  assign err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: rtl/hdmi_axi_rd_burst.sv
// ============================================================================
// Module   : hdmi_axi_rd_burst
// Brief    : AXI4 INCR read-burst master feeding the HDMI pixel line FIFO.
//            Error monitoring is built only when HDMI_RD_ERR_CHECK_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdmi_axi_rd_burst
  import hdmi_axi_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_BURST = 256
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic              kick,
  input  logic [31:0]       read_addr,
  input  logic [31:0]       read_num,
  output logic              busy,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [15:0]       err_cnt
);

  localparam logic [2:0]  c_arsize    = clog2_bytes(DATA_W);
  localparam logic [31:0] c_max_burst = 32'(MAX_BURST);

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;

  logic              w_accept;
  logic              w_in_r;
  logic              w_beat;
  logic [7:0]        w_arlen;

  assign w_accept = kick && (r_state == S_IDLE);
  assign w_in_r   = (r_state == S_R);
  assign w_beat   = w_in_r && m_axi_rvalid && pix_ready;
  assign w_arlen  = (read_num > c_max_burst) ? 8'(c_max_burst - 32'd1)
                                             : 8'(read_num - 32'd1);

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (kick) w_state_nxt = (read_num == 32'd0) ? S_DONE : S_AR;
      S_AR:   if (m_axi_arready) w_state_nxt = S_R;
      S_R:    if (w_beat && m_axi_rlast) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // AR payload captured once per request so it stays stable under arvalid.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_araddr <= '0;
      r_arlen  <= '0;
    end else if (w_accept && (read_num != 32'd0)) begin
      r_araddr <= BASE_ADDR + ADDR_W'(read_addr);
      r_arlen  <= w_arlen;
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arsize  = c_arsize;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arvalid = (r_state == S_AR);

  // R channel is a zero-latency pass-through into the line FIFO.
  assign pix_data     = m_axi_rdata;
  assign pix_valid    = w_in_r && m_axi_rvalid;
  assign m_axi_rready = w_in_r && pix_ready;

`ifdef HDMI_RD_ERR_CHECK_EN
  hdmi_rd_err_mon u_err_mon (
    .clk_vga (clk_vga),
    .rst_n   (rst_n),
    .start   (w_accept),
    .beat    (w_beat),
    .rresp   (m_axi_rresp),
    .rlast   (m_axi_rlast),
    .arlen   (r_arlen),
    .err_cnt (err_cnt)
  );
`else
  logic w_unused_resp;
  assign w_unused_resp = ^m_axi_rresp;
  assign err_cnt       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hdmi_axi_rd_burst.sv
// ============================================================================
// Module   : tb_hdmi_axi_rd_burst
// Brief    : Scoreboard bench for hdmi_axi_rd_burst; honours HDMI_RD_ERR_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hdmi_axi_rd_burst;

  localparam logic [31:0] c_base = 32'h1000_0000;

  logic        clk_vga = 1'b0;
  logic        rst_n = 1'b0;
  logic        kick = 1'b0;
  logic [31:0] read_addr = '0;
  logic [31:0] read_num = '0;
  logic        busy;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b1;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [15:0] err_cnt;

  hdmi_axi_rd_burst #(
    .DATA_W(32), .ADDR_W(32), .BASE_ADDR(c_base), .MAX_BURST(256)
  ) dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .kick(kick), .read_addr(read_addr),
    .read_num(read_num), .busy(busy), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .err_cnt(err_cnt)
  );

  initial forever #5 clk_vga = ~clk_vga;

  int          checks = 0;
  int          failures = 0;
  int          ar_hs = 0;
  int          exp_ar = 0;
  bit          bp_en = 1'b0;
  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_len_q[$];
  logic [31:0] exp_pix_q[$];

`ifdef HDMI_RD_ERR_CHECK_EN
  localparam bit c_err_en = 1'b1;
`else
  localparam bit c_err_en = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compares AR handshakes and FIFO pushes against the queues.
  initial forever begin
    @(negedge clk_vga);
    if (rst_n && m_axi_arvalid && m_axi_arready) begin
      ar_hs++;
      if (exp_addr_q.size() == 0) fail_now("ar_unexpected");
      else begin
        check("araddr", m_axi_araddr, exp_addr_q.pop_front());
        check("arlen", m_axi_arlen, exp_len_q.pop_front());
        check("arsize", m_axi_arsize, 3'd2);
        check("arburst", m_axi_arburst, 2'b01);
      end
    end
    if (rst_n && pix_valid && pix_ready) begin
      if (exp_pix_q.size() == 0) fail_now("pix_unexpected");
      else check("pix_data", pix_data, exp_pix_q.pop_front());
    end
  end

  initial forever begin
    @(posedge clk_vga);
    #1;
    if (bp_en) pix_ready = ~pix_ready;
  end

  task automatic do_kick(input logic [31:0] addr, input logic [31:0] num, input int hold);
    if (num != 0) begin
      exp_addr_q.push_back(c_base + addr);
      exp_len_q.push_back((num > 32'd256) ? 8'd255 : 8'(num - 1));
      exp_ar++;
    end
    read_addr = addr;
    read_num  = num;
    kick      = 1'b1;
    repeat (hold) @(posedge clk_vga);
    #1 kick = 1'b0;
  endtask

  task automatic drive_burst(input int n, input int bad_idx, input int abort_at,
                             input logic [31:0] tag);
    int t;
    bit hs;
    t = 0;
    while (ar_hs != exp_ar) begin
      @(posedge clk_vga);
      #1;
      t++;
      if (t > 100) begin
        fail_now("ar_timeout");
        return;
      end
    end
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        m_axi_rvalid = 1'b0;
        return;
      end
      m_axi_rdata  = tag + 32'(i);
      m_axi_rresp  = (i == bad_idx) ? 2'b10 : 2'b00;
      m_axi_rlast  = (i == n - 1);
      m_axi_rvalid = 1'b1;
      exp_pix_q.push_back(tag + 32'(i));
      t = 0;
      forever begin
        @(negedge clk_vga);
        check("rready_follows", m_axi_rready, pix_ready);
        hs = m_axi_rready;
        @(posedge clk_vga);
        #1;
        if (hs) break;
        t++;
        if (t > 100) begin
          fail_now("beat_timeout");
          m_axi_rvalid = 1'b0;
          return;
        end
      end
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
  endtask

  task automatic end_of_burst();
    check("busy_in_done", busy, 1'b1);
    @(posedge clk_vga);
    #1;
    check("busy_low_after", busy, 1'b0);
    check("pix_left", exp_pix_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk_vga);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_rready", m_axi_rready, 1'b0);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_araddr", m_axi_araddr, 32'h0);
    check("rst_arlen", m_axi_arlen, 8'h0);
    check("rst_err_cnt", err_cnt, 16'h0);
    @(negedge clk_vga) rst_n = 1'b1;
    @(posedge clk_vga);
    #1;

    // 64-beat burst, error response on beat 10
    do_kick(32'h400, 32'd64, 1);
    check("kick_busy", busy, 1'b1);
    check("kick_arvalid", m_axi_arvalid, 1'b1);
    drive_burst(64, 10, -1, 32'hA100_0000);
    end_of_burst();
    check("err_resp", err_cnt, c_err_en ? 16'd1 : 16'd0);

    // FIFO backpressure toggling every cycle
    bp_en = 1'b1;
    do_kick(32'h800, 32'd64, 1);
    drive_burst(64, -1, -1, 32'hA200_0000);
    bp_en = 1'b0;
    pix_ready = 1'b1;
    end_of_burst();

    // zero-length request
    do_kick(32'h0, 32'd0, 1);
    check("zero_busy", busy, 1'b1);
    check("zero_arvalid", m_axi_arvalid, 1'b0);
    @(posedge clk_vga);
    #1;
    check("zero_busy_low", busy, 1'b0);
    check("zero_ar_count", ar_hs, exp_ar);

    // clamped length with kick held for five cycles
    do_kick(32'h10, 32'd300, 5);
    drive_burst(256, -1, -1, 32'hA300_0000);
    end_of_burst();
    check("hold_ar_count", ar_hs, exp_ar);

    // early rlast on beat 31 of a 64-beat burst
    do_kick(32'h2000, 32'd64, 1);
    drive_burst(32, -1, -1, 32'hA400_0000);
    end_of_burst();
    check("err_early_rlast", err_cnt, c_err_en ? 16'd2 : 16'd0);

    // asynchronous reset mid-burst
    do_kick(32'h3000, 32'd64, 1);
    drive_burst(64, -1, 20, 32'hA500_0000);
    check("busy_pre_reset", busy, 1'b1);
    #2 rst_n = 1'b0;
    exp_pix_q.delete();
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_arvalid", m_axi_arvalid, 1'b0);
    check("arst_rready", m_axi_rready, 1'b0);
    check("arst_pix_valid", pix_valid, 1'b0);
    check("arst_err_cnt", err_cnt, 16'h0);
    repeat (2) @(posedge clk_vga);
    @(negedge clk_vga) rst_n = 1'b1;
    @(posedge clk_vga);
    #1;

    // fresh request after reset
    do_kick(32'h40, 32'd4, 1);
    check("post_arvalid", m_axi_arvalid, 1'b1);
    drive_burst(4, -1, -1, 32'hA600_0000);
    end_of_burst();
    check("final_ar_count", ar_hs, exp_ar);
    check("final_err_cnt", err_cnt, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
